// File: rtl/scan_loader.sv
// Scan-chain loader: streams host words LSB-first into a serial scan chain and
// returns the bits ejected from the chain tail as readback words.
module scan_loader #(
    parameter int CHAIN_LEN = 1024,
    parameter int WORD_W    = 32
) (
    input  logic              PCLK,
    input  logic              RESETN,
    input  logic              START,
    output logic              BUSY,
    output logic              DONE,
    input  logic [WORD_W-1:0] DIN,
    input  logic              DIN_VALID,
    output logic              DIN_READY,
    output logic              SE,
    output logic              SIN,
    input  logic              SOUT,
    output logic [WORD_W-1:0] DOUT,
    output logic              DOUT_VALID,
    input  logic              DOUT_READY,
    output logic [1:0]        STATE_DBG
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   bit_cnt;
    logic [IDX_W-1:0]   idx;
    logic [WORD_W-1:0]  din_q;
    logic [WORD_W-1:0]  cap_q;
    logic [WORD_W-1:0]  cap_next;
    logic               chain_end;
    logic               word_end;

    // Valid/ready: a word moves on any rising edge where valid and ready are
    // both high; a source holds valid and data stable until that edge.
    assign DIN_READY = (state == LOAD) && !DOUT_VALID;
    assign STATE_DBG = state;

    // Words start on WORD_W boundaries, so a word ends on a full word or at
    // the end of the chain, whichever comes first.
    always_comb begin
        cap_next      = cap_q;
        cap_next[idx] = SOUT;
        chain_end     = (32'(bit_cnt) + 32'd1) == 32'(CHAIN_LEN);
        word_end      = (32'(idx) == 32'(WORD_W - 1)) || chain_end;
    end

    always_ff @(posedge PCLK or negedge RESETN) begin
        if (!RESETN) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            idx        <= '0;
            din_q      <= '0;
            cap_q      <= '0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            SE         <= 1'b0;
            SIN        <= 1'b0;
            DOUT       <= '0;
            DOUT_VALID <= 1'b0;
        end else begin
            DONE <= 1'b0;
            if (DOUT_VALID && DOUT_READY) begin
                DOUT_VALID <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (START) begin
                        state   <= LOAD;
                        bit_cnt <= '0;
                        BUSY    <= 1'b1;
                    end
                end
                LOAD: begin
                    if (DIN_VALID && DIN_READY) begin
                        SE    <= 1'b1;
                        SIN   <= DIN[0];
                        din_q <= DIN >> 1;
                        cap_q <= '0;
                        idx   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    if (word_end) begin
                        SE         <= 1'b0;
                        SIN        <= 1'b0;
                        DOUT       <= cap_next;
                        DOUT_VALID <= 1'b1;
                        state      <= chain_end ? DRAIN : LOAD;
                    end else begin
                        idx   <= idx + IDX_W'(1);
                        cap_q <= cap_next;
                        SIN   <= din_q[0];
                        din_q <= din_q >> 1;
                    end
                end
                DRAIN: begin
                    if (DOUT_VALID && DOUT_READY) begin
                        state <= IDLE;
                        DONE  <= 1'b1;
                        BUSY  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
